// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system control register bank:
// IOC map, reset values and soft-reset FSM encoding.
package sys_ctrl_pkg;

  localparam logic [4:0] IOC_MOD_VER   = 5'h00;
  localparam logic [4:0] IOC_SYS_VER   = 5'h01;
  localparam logic [4:0] IOC_MANU_ID   = 5'h02;
  localparam logic [4:0] IOC_ERR_FLAGS = 5'h03;
  localparam logic [4:0] IOC_ERR_MASK  = 5'h04;
  localparam logic [4:0] IOC_DEBUG     = 5'h05;
  localparam logic [4:0] IOC_TX_GAP    = 5'h06;
  localparam logic [4:0] IOC_CNT_LO    = 5'h07;
  localparam logic [4:0] IOC_CNT_HI    = 5'h08;
  localparam logic [4:0] IOC_CTRL      = 5'h09;
  localparam logic [4:0] IOC_SCRATCH   = 5'h10;

  localparam logic [7:0] RST_DATA_OUT  = 8'h00;
  localparam logic [7:0] RST_DEBUG     = 8'h00;
  localparam logic [7:0] RST_SCRATCH   = 8'h00;

  typedef enum logic {
    ST_IDLE,
    ST_PULSE
  } srst_state_e;

  function automatic logic is_scratch(
    input logic [4:0] ioc,
    input int         n
  );
    return ioc[4] && (int'(ioc[3:0]) < n);
  endfunction

endpackage

// File: rtl/sys_ctrl_regbank_if.sv
// IOC control bus between the SPI command decoder
// and the system control register bank.
interface sys_ctrl_regbank_if;
  logic [4:0] i_ioc;
  logic [7:0] i_data_in;
  logic [7:0] o_data_out;
  logic       i_cs;
  logic       i_fetch_cmd;
  logic       i_load_cmd;

  modport master (
    output i_ioc, i_data_in, i_cs,
    output i_fetch_cmd, i_load_cmd,
    input  o_data_out
  );

  modport slave (
    input  i_ioc, i_data_in, i_cs,
    input  i_fetch_cmd, i_load_cmd,
    output o_data_out
  );
endinterface

// File: rtl/sys_ctrl_err_tracker.sv
// Sticky masked error flags, saturating event counter
// with high-byte shadow, and interrupt generation.
module sys_ctrl_err_tracker #(
  parameter int NUM_ERR   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_ERR-1:0]   i_err_evt,
  input  logic                 i_flags_w1c,
  input  logic [NUM_ERR-1:0]   i_w1c_bits,
  input  logic                 i_mask_we,
  input  logic [NUM_ERR-1:0]   i_mask_data,
  input  logic                 i_cnt_clr,
  input  logic                 i_snap,
  output logic [NUM_ERR-1:0]   o_flags,
  output logic [NUM_ERR-1:0]   o_mask,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [CNT_WIDTH-9:0] o_shadow,
  output logic                 o_cnt_sat,
  output logic                 o_err_irq
);

  logic [NUM_ERR-1:0]   r_flags;
  logic [NUM_ERR-1:0]   r_mask;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-9:0] r_shadow;
  logic [NUM_ERR-1:0]   w_clr_bits;
  logic                 w_hit;
  logic                 w_sat;

  assign w_clr_bits = i_flags_w1c ? i_w1c_bits : '0;
  assign w_hit      = |(i_err_evt & ~r_mask);
  assign w_sat      = &r_cnt;

  // New events are OR-ed after the clear so set beats W1C
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flags <= '0;
      r_mask  <= '1;
    end else begin
      r_flags <= (r_flags & ~w_clr_bits) | i_err_evt;
      if (i_mask_we) r_mask <= i_mask_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (i_cnt_clr) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (w_hit && !w_sat) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (i_snap) r_shadow <= r_cnt[CNT_WIDTH-1:8];
    end
  end

  assign o_flags   = r_flags;
  assign o_mask    = r_mask;
  assign o_cnt     = r_cnt;
  assign o_shadow  = r_shadow;
  assign o_cnt_sat = w_sat;
  assign o_err_irq = |(r_flags & ~r_mask);

endmodule

// File: rtl/sys_ctrl_regbank.sv
// System control register bank: IOC decode, read mux,
// soft-reset pulse FSM and scratch registers.
module sys_ctrl_regbank
  import sys_ctrl_pkg::*;
#(
  parameter int          NUM_ERR         = 8,
  parameter int          CNT_WIDTH       = 16,
  parameter int          GAP_WIDTH       = 4,
  parameter int          NUM_SCRATCH     = 4,
  parameter int          SOFT_RST_CYCLES = 16,
  parameter logic [7:0]  MODULE_VERSION  = 8'h02,
  parameter logic [7:0]  SYSTEM_VERSION  = 8'h01,
  parameter logic [7:0]  MANU_ID         = 8'h01
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  sys_ctrl_regbank_if.slave        bus,
  input  logic [NUM_ERR-1:0]       i_err_evt,
  output logic                     o_err_irq,
  output logic [7:0]               o_debug_modes,
  output logic [GAP_WIDTH-1:0]     o_tx_sample_gap,
  output logic                     o_soft_rst,
  output logic [8*NUM_SCRATCH-1:0] o_scratch
);

  logic                              w_rd;
  logic                              w_wr;
  logic                              w_is_scr;
  logic [7:0]                        w_rdata;
  logic [7:0]                        w_scr_rd;
  logic                              w_srst_req;
  logic [NUM_ERR-1:0]                w_flags;
  logic [NUM_ERR-1:0]                w_mask;
  logic [CNT_WIDTH-1:0]              w_cnt;
  logic [CNT_WIDTH-9:0]              w_shadow;
  logic                              w_cnt_sat;
  logic [7:0]                        r_data_out;
  logic [7:0]                        r_debug;
  logic [GAP_WIDTH-1:0]              r_gap;
  logic [NUM_SCRATCH-1:0][7:0]       r_scratch;
  srst_state_e                       r_state;
  srst_state_e                       w_state_nxt;
  logic [7:0]                        r_rst_cnt;
  logic [7:0]                        w_rst_cnt_nxt;

  assign w_rd     = bus.i_cs & bus.i_fetch_cmd;
  assign w_wr     = bus.i_cs & bus.i_load_cmd & ~bus.i_fetch_cmd;
  assign w_is_scr = is_scratch(bus.i_ioc, NUM_SCRATCH);

  assign w_srst_req = w_wr && (bus.i_ioc == IOC_CTRL)
                    && bus.i_data_in[0];

  sys_ctrl_err_tracker #(
    .NUM_ERR   (NUM_ERR),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_err (
    .i_clk       (i_sys_clk),
    .i_rst       (i_rst),
    .i_err_evt   (i_err_evt),
    .i_flags_w1c (w_wr && (bus.i_ioc == IOC_ERR_FLAGS)),
    .i_w1c_bits  (bus.i_data_in[NUM_ERR-1:0]),
    .i_mask_we   (w_wr && (bus.i_ioc == IOC_ERR_MASK)),
    .i_mask_data (bus.i_data_in[NUM_ERR-1:0]),
    .i_cnt_clr   (w_wr && (bus.i_ioc == IOC_CTRL)
                  && bus.i_data_in[1]),
    .i_snap      (w_rd && (bus.i_ioc == IOC_CNT_LO)),
    .o_flags     (w_flags),
    .o_mask      (w_mask),
    .o_cnt       (w_cnt),
    .o_shadow    (w_shadow),
    .o_cnt_sat   (w_cnt_sat),
    .o_err_irq   (o_err_irq)
  );

  always_comb begin
    w_scr_rd = 8'h00;
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (bus.i_ioc[3:0] == 4'(k)) w_scr_rd = r_scratch[k];
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    unique case (1'b1)
      w_is_scr:                     w_rdata = w_scr_rd;
      (bus.i_ioc == IOC_MOD_VER):   w_rdata = MODULE_VERSION;
      (bus.i_ioc == IOC_SYS_VER):   w_rdata = SYSTEM_VERSION;
      (bus.i_ioc == IOC_MANU_ID):   w_rdata = MANU_ID;
      (bus.i_ioc == IOC_ERR_FLAGS): w_rdata = 8'(w_flags);
      (bus.i_ioc == IOC_ERR_MASK):  w_rdata = 8'(w_mask);
      (bus.i_ioc == IOC_DEBUG):     w_rdata = r_debug;
      (bus.i_ioc == IOC_TX_GAP):    w_rdata = 8'(r_gap);
      (bus.i_ioc == IOC_CNT_LO):    w_rdata = w_cnt[7:0];
      (bus.i_ioc == IOC_CNT_HI):    w_rdata = 8'(w_shadow);
      (bus.i_ioc == IOC_CTRL):
        w_rdata = {6'b0, w_cnt_sat, r_state == ST_PULSE};
      default:                      w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= RST_DATA_OUT;
      r_debug    <= RST_DEBUG;
      r_gap      <= '0;
      r_scratch  <= '{default: RST_SCRATCH};
    end else begin
      if (w_rd) r_data_out <= w_rdata;
      if (w_wr && (bus.i_ioc == IOC_DEBUG))
        r_debug <= bus.i_data_in;
      if (w_wr && (bus.i_ioc == IOC_TX_GAP))
        r_gap <= bus.i_data_in[GAP_WIDTH-1:0];
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (w_wr && w_is_scr && (bus.i_ioc[3:0] == 4'(k)))
          r_scratch[k] <= bus.i_data_in;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
    end
  end

  // A request while pulsing reloads the count and stretches the pulse
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_srst_req) begin
          w_state_nxt   = ST_PULSE;
          w_rst_cnt_nxt = 8'(SOFT_RST_CYCLES);
        end
      end
      ST_PULSE: begin
        if (w_srst_req)
          w_rst_cnt_nxt = 8'(SOFT_RST_CYCLES);
        else if (r_rst_cnt == 8'd1)
          w_state_nxt = ST_IDLE;
        else
          w_rst_cnt_nxt = r_rst_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.o_data_out   = r_data_out;
  assign o_debug_modes    = r_debug;
  assign o_tx_sample_gap  = r_gap;
  assign o_soft_rst       = (r_state == ST_PULSE);
  assign o_scratch        = r_scratch;

endmodule
